// File: rtl/oled_pixel_feeder.sv
// rtl/oled_pixel_feeder.sv - RGB565 pixel FIFO serialised as hi/lo bytes toward the OLED controller
module oled_pixel_feeder #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int FRAME_PIXELS = 6144,
    parameter int CNT_W        = 13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [15:0]       wr_data_i,
    output logic              full_o,
    output logic [ADDR_W:0]   level_o,
    input  logic              frame_start_i,
    input  logic              spi_done_i,
    output logic [7:0]        pixel_o,
    output logic              pixel_valid_o,
    output logic              frame_done_o,
    output logic              overflow_o,
    output logic              underrun_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HI,
        S_GAP1,
        S_LO,
        S_GAP2,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]  FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_PIX   = CNT_W'(FRAME_PIXELS - 1);

    state_t            state;
    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic [15:0]       hold;
    logic [CNT_W-1:0]  pix_cnt;
    logic              push;
    logic              pop;
    logic              empty;

    // Full is judged on the registered level, so a pop in the same cycle never rescues a write
    assign full_o  = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign level_o = level;
    assign push    = wr_en_i && !full_o;
    assign pop     = (state == S_FETCH) && !empty;
    assign busy_o  = (state != S_IDLE);

    // Word storage; contents need no reset since only words below the level are ever read
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // FIFO pointers wrap naturally at DEPTH; level tracks push/pop imbalance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (ADDR_W + 1)'(1);
                2'b01:   level <= level - (ADDR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Byte serialiser: every output is registered and changes on the edge entering its state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            hold          <= '0;
            pix_cnt       <= '0;
            pixel_o       <= '0;
            pixel_valid_o <= 1'b0;
            frame_done_o  <= 1'b0;
            overflow_o    <= 1'b0;
            underrun_o    <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start_i) begin
                        pix_cnt    <= '0;
                        underrun_o <= 1'b0;
                        overflow_o <= 1'b0;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!empty) begin
                        hold          <= mem[rd_ptr];
                        pixel_o       <= mem[rd_ptr][15:8];
                        pixel_valid_o <= 1'b1;
                        state         <= S_HI;
                    end else if (pix_cnt != '0) begin
                        underrun_o <= 1'b1;
                    end
                end
                S_HI: begin
                    if (spi_done_i) begin
                        pixel_valid_o <= 1'b0;
                        state         <= S_GAP1;
                    end
                end
                S_GAP1: begin
                    pixel_o       <= hold[7:0];
                    pixel_valid_o <= 1'b1;
                    state         <= S_LO;
                end
                S_LO: begin
                    if (spi_done_i) begin
                        pixel_valid_o <= 1'b0;
                        if (pix_cnt == LAST_PIX) begin
                            frame_done_o <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            pix_cnt <= pix_cnt + CNT_W'(1);
                            state   <= S_GAP2;
                        end
                    end
                end
                S_GAP2: begin
                    state <= S_FETCH;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            // A dropped write is flagged even in the cycle a frame start clears the flag
            if (wr_en_i && full_o) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oled_pixel_feeder.sv
// tb/tb_oled_pixel_feeder.sv - self-checking bench for oled_pixel_feeder
module tb_oled_pixel_feeder;

    localparam int DEPTH = 16;
    localparam int FP    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        frame_start = 1'b0;
    logic        spi_done = 1'b0;
    logic        full;
    logic [4:0]  level;
    logic [7:0]  pixel;
    logic        valid;
    logic        frame_done;
    logic        overflow;
    logic        underrun;
    logic        busy;

    logic        s_wr_en = 1'b0;
    logic [15:0] s_wr_data = '0;
    logic        s_start = 1'b0;
    logic        s_done = 1'b0;
    logic        s_full;
    logic [4:0]  s_level;
    logic [7:0]  s_pixel;
    logic        s_valid;
    logic        s_fdone;
    logic        s_ovf;
    logic        s_unr;
    logic        s_busy;

    oled_pixel_feeder #(.DEPTH(16), .ADDR_W(4), .FRAME_PIXELS(FP), .CNT_W(13)) u_dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .full_o(full), .level_o(level), .frame_start_i(frame_start), .spi_done_i(spi_done),
        .pixel_o(pixel), .pixel_valid_o(valid), .frame_done_o(frame_done),
        .overflow_o(overflow), .underrun_o(underrun), .busy_o(busy)
    );

    oled_pixel_feeder #(.DEPTH(16), .ADDR_W(4), .FRAME_PIXELS(1), .CNT_W(13)) u_one (
        .clk_i(clk), .rst_i(rst), .wr_en_i(s_wr_en), .wr_data_i(s_wr_data),
        .full_o(s_full), .level_o(s_level), .frame_start_i(s_start), .spi_done_i(s_done),
        .pixel_o(s_pixel), .pixel_valid_o(s_valid), .frame_done_o(s_fdone),
        .overflow_o(s_ovf), .underrun_o(s_unr), .busy_o(s_busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference model state
    bit          model_on = 1'b0;
    logic [15:0] q[$];
    logic [7:0]  log_b[$];
    logic [15:0] cur = '0;
    logic [7:0]  last_byte = '0;
    bit          m_ovf = 1'b0, m_unr = 1'b0, m_busy = 1'b0;
    bit          m_at_fetch = 1'b0, g2_pending = 1'b0, busy_drop = 1'b0;
    int          phase = 0;
    int          frame_bytes = 0;
    int          sim_cnt = 0;
    int          rdelay = 3;
    int          rcnt = 0;
    bit          rrun = 1'b0, prev_valid = 1'b0;

    logic        a_rst = 1'b0, a_wr = 1'b0, a_start = 1'b0, a_done = 1'b0;
    logic [15:0] a_wd = '0;

    // Capture what the DUT sees at each active edge
    always @(posedge clk) begin
        a_rst   = rst;
        a_wr    = wr_en;
        a_wd    = wr_data;
        a_start = frame_start;
        a_done  = spi_done;
    end

    // Advance the model by one edge, compare every output, then act as the SPI master
    always @(negedge clk) begin
        int pre;
        bit start_ok, set_fetch, exp_valid, exp_fd;
        if (model_on) begin
            exp_valid = 1'b0;
            exp_fd    = 1'b0;
            if (a_rst) begin
                q.delete();
                m_ovf = 0; m_unr = 0; m_busy = 0; m_at_fetch = 0;
                g2_pending = 0; busy_drop = 0; phase = 0; frame_bytes = 0;
                last_byte = '0;
            end else begin
                pre = q.size();
                start_ok = a_start && !m_busy;
                set_fetch = g2_pending;
                g2_pending = 1'b0;
                if (busy_drop) begin
                    m_busy = 1'b0;
                    busy_drop = 1'b0;
                end
                if (start_ok) begin
                    m_busy = 1'b1; m_ovf = 1'b0; m_unr = 1'b0; frame_bytes = 0;
                end
                if (a_wr) begin
                    if (pre < DEPTH) q.push_back(a_wd);
                    else m_ovf = 1'b1;
                end
                case (phase)
                    0: if (m_at_fetch) begin
                        if (pre > 0) begin
                            cur = q.pop_front();
                            if (a_wr && pre < DEPTH) sim_cnt++;
                            last_byte = cur[15:8];
                            log_b.push_back(last_byte);
                            frame_bytes++;
                            exp_valid = 1'b1;
                            phase = 1;
                            m_at_fetch = 1'b0;
                        end else if (frame_bytes > 0) begin
                            m_unr = 1'b1;
                        end
                    end
                    1: if (a_done) phase = 2;
                       else exp_valid = 1'b1;
                    2: begin
                        last_byte = cur[7:0];
                        log_b.push_back(last_byte);
                        frame_bytes++;
                        exp_valid = 1'b1;
                        phase = 3;
                    end
                    default: if (a_done) begin
                        phase = 0;
                        if (frame_bytes == 2 * FP) begin
                            exp_fd = 1'b1;
                            busy_drop = 1'b1;
                        end else begin
                            g2_pending = 1'b1;
                        end
                    end else begin
                        exp_valid = 1'b1;
                    end
                endcase
                if (set_fetch || start_ok) m_at_fetch = 1'b1;
            end
            chk("level", level, q.size());
            chk("full", full, (q.size() == DEPTH));
            chk("overflow", overflow, m_ovf);
            chk("underrun", underrun, m_unr);
            chk("busy", busy, m_busy);
            chk("pixel_valid", valid, exp_valid);
            chk("pixel", pixel, last_byte);
            chk("frame_done", frame_done, exp_fd);
        end
        spi_done = 1'b0;
        if (model_on) begin
            if (!valid) rrun = 1'b0;
            else if (!prev_valid) begin
                rrun = 1'b1;
                rcnt = rdelay;
            end else if (rrun) begin
                if (rcnt <= 1) begin
                    spi_done = 1'b1;
                    rrun = 1'b0;
                end else rcnt--;
            end
            prev_valid = valid;
        end
    end

    task automatic write_word(input logic [15:0] d);
        wr_en = 1'b1;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input int limit);
        int n = 0;
        while (!frame_done && n < limit) begin
            step();
            n++;
        end
        chk("frame_done_seen", frame_done, 1);
    endtask

    initial begin
        int n;
        int sent;
        int frames_started;
        int frames_done;

        // reset and enable the model on a reset edge
        step();
        model_on = 1'b1;
        step();
        rst = 1'b0;

        // reset clears a partly filled FIFO
        write_word(16'h1111);
        write_word(16'h2222);
        write_word(16'h3333);
        chk("pre_reset_level", level, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("reset_level", level, 0);
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_pixel", pixel, 0);

        // one full frame, with start latency
        write_word(16'hF81F);
        write_word(16'h1234);
        write_word(16'hABCD);
        write_word(16'h0055);
        log_b.delete();
        pulse_start();
        chk("lat_fetch_valid", valid, 0);
        step();
        chk("lat_hi_valid", valid, 1);
        chk("lat_hi_pixel", pixel, 8'hF8);
        wait_frame(300);
        chk("f1_count", log_b.size(), 8);
        chk("f1_b0", log_b[0], 8'hF8);
        chk("f1_b1", log_b[1], 8'h1F);
        chk("f1_b3", log_b[3], 8'h34);
        chk("f1_b7", log_b[7], 8'h55);
        step();
        chk("f1_idle", busy, 0);

        // overflow: 17 back-to-back writes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 16'(16'h0100 + i);
            step();
            if (i == 15) begin
                chk("ovf_full16", full, 1);
                chk("ovf_level16", level, 16);
                chk("ovf_not_yet", overflow, 0);
            end
        end
        wr_en = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, 16);
        log_b.delete();
        for (int f = 0; f < 4; f++) begin
            pulse_start();
            if (f == 0) chk("ovf_cleared", overflow, 0);
            wait_frame(300);
            step();
        end
        chk("ovf_drain_count", log_b.size(), 32);
        chk("ovf_first_hi", log_b[0], 8'h01);
        chk("ovf_last_hi", log_b[30], 8'h01);
        chk("ovf_last_lo", log_b[31], 8'h0F);
        chk("ovf_drained", level, 0);

        // underrun after two pixels, then resume
        write_word(16'hA1A2);
        write_word(16'hB1B2);
        log_b.delete();
        pulse_start();
        n = 0;
        while (!underrun && n < 300) begin
            step();
            n++;
        end
        chk("unr_set", underrun, 1);
        chk("unr_valid", valid, 0);
        chk("unr_busy", busy, 1);
        chk("unr_bytes", log_b.size(), 4);
        write_word(16'hC1C2);
        write_word(16'hD1D2);
        wait_frame(300);
        chk("unr_total", log_b.size(), 8);
        chk("unr_b4", log_b[4], 8'hC1);
        chk("unr_b7", log_b[7], 8'hD2);
        step();

        // streaming at level 1 with write and pop on the same edge
        log_b.delete();
        sim_cnt = 0;
        sent = 0;
        frames_started = 0;
        frames_done = 0;
        n = 0;
        while (frames_done < 10 && n < 4000) begin
            wr_en = 1'b0;
            frame_start = 1'b0;
            if (sent < 40 && (level == 0 || (level == 1 && m_at_fetch))) begin
                wr_en = 1'b1;
                wr_data = 16'(16'h3000 + sent * 16'h0111);
                sent++;
            end
            if (!busy && frames_started < 10) begin
                frame_start = 1'b1;
                frames_started++;
            end
            step();
            if (frame_done) frames_done++;
            n++;
        end
        wr_en = 1'b0;
        frame_start = 1'b0;
        chk("stream_frames", frames_done, 10);
        chk("stream_bytes", log_b.size(), 80);
        chk("stream_simul", (sim_cnt >= 30), 1);
        chk("stream_b0", log_b[0], 8'h30);
        chk("stream_b78", log_b[78], 8'h59);
        chk("stream_b79", log_b[79], 8'h97);
        step();

        // frame_start during HI is ignored; reset during LO abandons the frame
        write_word(16'hE1E2);
        write_word(16'hF1F2);
        pulse_start();
        n = 0;
        while (phase != 1 && n < 50) begin
            step();
            n++;
        end
        chk("mid_hi_reached", phase, 1);
        pulse_start();
        chk("mid_hi_valid", valid, 1);
        chk("mid_hi_pixel", pixel, 8'hE1);
        n = 0;
        while (phase != 3 && n < 50) begin
            step();
            n++;
        end
        chk("mid_lo_reached", phase, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_fdone", frame_done, 0);
        chk("mid_rst_level", level, 0);
        step();
        chk("mid_rst_fdone2", frame_done, 0);
        write_word(16'h1357);
        write_word(16'h2468);
        write_word(16'h9ABC);
        write_word(16'hDEF0);
        log_b.delete();
        pulse_start();
        wait_frame(300);
        chk("post_rst_bytes", log_b.size(), 8);
        chk("post_rst_b0", log_b[0], 8'h13);
        chk("post_rst_b5", log_b[5], 8'hBC);
        chk("post_rst_b7", log_b[7], 8'hF0);
        step();

        // single-pixel frame on the FRAME_PIXELS=1 instance, 20-cycle SPI turnaround
        s_wr_en = 1'b1;
        s_wr_data = 16'hF81F;
        step();
        s_wr_en = 1'b0;
        chk("one_level", s_level, 1);
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        chk("one_fetch_valid", s_valid, 0);
        chk("one_busy", s_busy, 1);
        step();
        chk("one_hi_valid", s_valid, 1);
        chk("one_hi_pixel", s_pixel, 8'hF8);
        repeat (19) step();
        chk("one_hi_held", s_valid, 1);
        s_done = 1'b1;
        step();
        s_done = 1'b0;
        chk("one_gap_valid", s_valid, 0);
        step();
        chk("one_lo_valid", s_valid, 1);
        chk("one_lo_pixel", s_pixel, 8'h1F);
        repeat (19) step();
        chk("one_no_early_done", s_fdone, 0);
        s_done = 1'b1;
        step();
        s_done = 1'b0;
        chk("one_fdone", s_fdone, 1);
        chk("one_done_valid", s_valid, 0);
        step();
        chk("one_fdone_pulse", s_fdone, 0);
        chk("one_idle", s_busy, 0);
        chk("one_pixel_hold", s_pixel, 8'h1F);
        chk("one_flags", {s_full, s_ovf, s_unr}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

endmodule
